// File: rtl/wishbone_slave_mem_if.sv
// Wishbone classic (B3) bus bundle between a master and the memory slave.
// wait_cycles is carried with the bus so the master can set the response delay per transfer.
interface wishbone_slave_mem_if #(
    parameter int adr_width = 8,
    parameter int dat_width = 32,
    parameter int sel_width = dat_width / 8
);
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [adr_width-1:0] adr;
    logic [sel_width-1:0] sel;
    logic [dat_width-1:0] datwr;
    logic [3:0]           wait_cycles;
    logic [dat_width-1:0] datrd;
    logic                 ack;
    logic                 err;

    modport master (
        output cyc, stb, we, adr, sel, datwr, wait_cycles,
        input  datrd, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, sel, datwr, wait_cycles,
        output datrd, ack, err
    );
endinterface

// File: rtl/wishbone_slave_mem.sv
// Wishbone classic slave over a byte-lane-writable word memory, with err for out-of-range words.
// Latency: ack/err is a one-cycle pulse N+1 cycles after the accepting edge (N = latched wait_cycles).
// Backpressure: one transfer at a time; requests are sampled only in IDLE with no termination pulse high.
module wishbone_slave_mem #(
    parameter int adr_width = 8,
    parameter int dat_width = 32,
    parameter int sel_width = dat_width / 8,
    parameter int depth     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    wishbone_slave_mem_if.slave  bus
);
    localparam int off_width = $clog2(sel_width);
    localparam int idx_width = adr_width - off_width;
    localparam int mem_aw    = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [idx_width:0] depth_v = (idx_width + 1)'(depth);

    typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 req;
    logic [idx_width-1:0] idx;
    logic                 unused_adr;

    logic [3:0]           cnt;
    logic                 lat_we;
    logic                 lat_ok;
    logic [mem_aw-1:0]    lat_idx;
    logic [sel_width-1:0] lat_sel;
    logic [dat_width-1:0] lat_dat;

    logic                 ack_q;
    logic                 err_q;
    logic [dat_width-1:0] datrd_q;

    logic [dat_width-1:0] mem [depth];

    assign req        = bus.cyc & bus.stb;
    assign idx        = bus.adr[adr_width-1:off_width];
    assign unused_adr = ^bus.adr;

    assign bus.ack    = ack_q;
    assign bus.err    = err_q;
    assign bus.datrd  = datrd_q;

    // The pulse of the previous transfer blocks IDLE so a held request waits one extra cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req && !ack_q && !err_q) begin
                    accept    = 1'b1;
                    state_nxt = (bus.wait_cycles == 4'd0) ? TERM : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd1) begin
                    state_nxt = TERM;
                end
            end
            TERM:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 4'd0;
            lat_we  <= 1'b0;
            lat_ok  <= 1'b0;
            lat_idx <= '0;
            lat_sel <= '0;
            lat_dat <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            datrd_q <= '0;
        end else begin
            ack_q   <= (state == TERM) && lat_ok;
            err_q   <= (state == TERM) && !lat_ok;
            datrd_q <= ((state == TERM) && lat_ok && !lat_we) ? mem[lat_idx] : '0;
            if (accept) begin
                cnt     <= bus.wait_cycles;
                lat_we  <= bus.we;
                lat_ok  <= ({1'b0, idx} < depth_v);
                lat_idx <= bus.adr[off_width +: mem_aw];
                lat_sel <= bus.sel;
                lat_dat <= bus.datwr;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Memory has no reset so it can map onto block RAM; the write lands with the ack edge.
    always_ff @(posedge clk) begin
        if (!rst && (state == TERM) && lat_ok && lat_we) begin
            for (int i = 0; i < sel_width; i++) begin
                if (lat_sel[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_dat[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_wishbone_slave_mem.sv
// Directed self-checking bench for wishbone_slave_mem (adr_width 12, depth 64).
module tb_wishbone_slave_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wishbone_slave_mem_if #(.adr_width(12), .dat_width(32)) bus ();

    wishbone_slave_mem #(
        .adr_width (12),
        .dat_width (32),
        .depth     (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Runs one complete transfer; lat counts edges from the accepting edge to the first edge showing ack/err.
    task automatic xfer(input logic w, input logic [11:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [3:0] n,
                        output int lat, output logic got_ack, output logic got_err,
                        output logic [31:0] rd, output logic early_nz);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w; bus.adr = a;
        bus.sel = s; bus.datwr = d; bus.wait_cycles = n;
        lat = -1; got_ack = 1'b0; got_err = 1'b0; rd = '0; early_nz = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.ack || bus.err) begin
                lat = k; got_ack = bus.ack; got_err = bus.err; rd = bus.datrd;
                break;
            end
            if (bus.datrd !== 32'h0) early_nz = 1'b1;
        end
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        checks++; if (bus.datrd !== 32'h0) begin errors++; $display("FAIL reset_datrd: got %h expected 0", bus.datrd); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat; logic a, e, nz; logic [31:0] rd;
        xfer(1'b1, 12'h00C, 4'hF, 32'hDEADBEEF, 4'd0, lat, a, e, rd, nz);
        checks++; if (lat !== 1 || a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL basic_wr_ack: lat %0d ack %b err %b expected lat 1 ack 1 err 0", lat, a, e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL basic_wr_datrd: got %h expected 0", rd); end
        xfer(1'b0, 12'h00C, 4'h0, 32'h0, 4'd0, lat, a, e, rd, nz);
        checks++; if (lat !== 1 || a !== 1'b1) begin errors++; $display("FAIL basic_rd_ack: lat %0d ack %b expected lat 1 ack 1", lat, a); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h expected deadbeef", rd); end
        checks++; if (bus.datrd !== 32'h0) begin errors++; $display("FAIL basic_datrd_clear: got %h expected 0", bus.datrd); end
    endtask

    task automatic test_byte_mask;
        int lat; logic a, e, nz; logic [31:0] rd;
        xfer(1'b1, 12'h00C, 4'h5, 32'h11223344, 4'd0, lat, a, e, rd, nz);
        xfer(1'b0, 12'h00C, 4'h0, 32'h0, 4'd0, lat, a, e, rd, nz);
        checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL mask_rd_data: got %h expected de22be44", rd); end
        xfer(1'b1, 12'h00C, 4'h0, 32'hFFFFFFFF, 4'd0, lat, a, e, rd, nz);
        checks++; if (a !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL sel0_ack: ack %b err %b expected ack 1 err 0", a, e); end
        xfer(1'b0, 12'h00C, 4'hF, 32'h0, 4'd0, lat, a, e, rd, nz);
        checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL sel0_unchanged: got %h expected de22be44", rd); end
    endtask

    task automatic test_wait_states;
        int lat; logic a, e, nz; logic [31:0] rd;
        xfer(1'b0, 12'h00F, 4'h0, 32'h0, 4'd3, lat, a, e, rd, nz);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wait3_lat: got %0d expected 4", lat); end
        checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL wait3_data: got %h expected de22be44", rd); end
        checks++; if (nz !== 1'b0) begin errors++; $display("FAIL wait3_early_datrd: got %b expected 0", nz); end
        xfer(1'b0, 12'h00C, 4'h0, 32'h0, 4'd15, lat, a, e, rd, nz);
        checks++; if (lat !== 16 || a !== 1'b1) begin errors++; $display("FAIL wait15_lat: lat %0d ack %b expected lat 16 ack 1", lat, a); end
        checks++; if (nz !== 1'b0) begin errors++; $display("FAIL wait15_early_datrd: got %b expected 0", nz); end
    endtask

    task automatic test_error;
        int lat; logic a, e, nz; logic [31:0] rd;
        xfer(1'b1, 12'h000, 4'hF, 32'h0000A5A5, 4'd0, lat, a, e, rd, nz);
        xfer(1'b1, 12'h100, 4'hF, 32'hFFFFFFFF, 4'd0, lat, a, e, rd, nz);
        checks++; if (lat !== 1 || a !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL err_wr: lat %0d ack %b err %b expected lat 1 ack 0 err 1", lat, a, e); end
        xfer(1'b0, 12'h100, 4'hF, 32'h0, 4'd2, lat, a, e, rd, nz);
        checks++; if (lat !== 3 || a !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL err_rd: lat %0d ack %b err %b expected lat 3 ack 0 err 1", lat, a, e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_rd_datrd: got %h expected 0", rd); end
        xfer(1'b0, 12'h000, 4'h0, 32'h0, 4'd0, lat, a, e, rd, nz);
        checks++; if (rd !== 32'h0000A5A5) begin errors++; $display("FAIL err_mem_unchanged: got %h expected 0000a5a5", rd); end
        xfer(1'b1, 12'h0FC, 4'hF, 32'h13579BDF, 4'd0, lat, a, e, rd, nz);
        xfer(1'b0, 12'h0FC, 4'h0, 32'h0, 4'd0, lat, a, e, rd, nz);
        checks++; if (a !== 1'b1 || rd !== 32'h13579BDF) begin errors++; $display("FAIL last_word: ack %b data %h expected ack 1 data 13579bdf", a, rd); end
    endtask

    task automatic test_abort;
        int lat; logic a, e, nz; logic [31:0] rd; logic seen;
        xfer(1'b1, 12'h014, 4'hF, 32'h55555555, 4'd0, lat, a, e, rd, nz);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 12'h014;
        bus.sel = 4'hF; bus.datwr = 32'hAAAAAAAA; bus.wait_cycles = 4'd5;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 bus.stb = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.ack || bus.err) seen = 1'b1;
        end
        bus.cyc = 1'b0; bus.we = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_term: got %b expected 0", seen); end
        xfer(1'b0, 12'h014, 4'h0, 32'h0, 4'd0, lat, a, e, rd, nz);
        checks++; if (lat !== 1 || rd !== 32'h55555555) begin errors++; $display("FAIL abort_no_write: lat %0d data %h expected lat 1 data 55555555", lat, rd); end
    endtask

    task automatic test_reset_in_wait;
        int lat; logic a, e, nz; logic [31:0] rd;
        xfer(1'b1, 12'h01C, 4'hF, 32'h01020304, 4'd0, lat, a, e, rd, nz);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 12'h01C;
        bus.sel = 4'hF; bus.datwr = 32'h0BADF00D; bus.wait_cycles = 4'd8;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.ack !== 1'b0 || bus.err !== 1'b0 || bus.datrd !== 32'h0) begin errors++; $display("FAIL rst_wait_outputs: ack %b err %b datrd %h expected 0 0 0", bus.ack, bus.err, bus.datrd); end
        rst = 1'b0; bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 12'h01C, 4'h0, 32'h0, 4'd0, lat, a, e, rd, nz);
        checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL rst_wait_old_data: got %h expected 01020304", rd); end
    endtask

    task automatic test_back_to_back;
        logic [6:0] pattern; logic both;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 12'h00C;
        bus.sel = 4'hF; bus.wait_cycles = 4'd0;
        pattern = '0; both = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            pattern[k-1] = bus.ack;
            if (bus.ack && bus.err) both = 1'b1;
        end
        bus.cyc = 1'b0; bus.stb = 1'b0;
        @(posedge clk); #1;
        checks++; if (pattern !== 7'b1001001) begin errors++; $display("FAIL b2b_ack_pattern: got %b expected 1001001", pattern); end
        checks++; if (both !== 1'b0) begin errors++; $display("FAIL b2b_ack_err_overlap: got %b expected 0", both); end
    endtask

    initial begin
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0;
        bus.sel = '0; bus.datwr = '0; bus.wait_cycles = '0;
        test_reset();
        test_basic();
        test_byte_mask();
        test_wait_states();
        test_error();
        test_abort();
        test_reset_in_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
